modulator: RTL and testbench



---
 rtl/modulator_pkg.sv | 15 +
 rtl/modulator_slot_timer.sv | 51 +++++
 rtl/modulator.sv | 88 ++++++++
 tb/tb_modulator.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/modulator_pkg.sv
// Shared types and modulation-parameter word layout for the pulse modulator.
// The field order matches the UART modulation-parameter message decoder.
package modulator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // mod_params is MOD_NUM_FIELDS fields of CTR_W bits each
  localparam int MOD_PW_FIELD   = 0;
  localparam int MOD_BP_FIELD   = 1;
  localparam int MOD_NUM_FIELDS = 2;

endpackage

// File: rtl/modulator_slot_timer.sv
// Slot and bit-index counters for the modulator; flags the last cycle of each
// slot and the last cycle of the last slot in a byte.
module modulator_slot_timer #(
  parameter int DATA_W = 8,
  parameter int CTR_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             run_i,
  input  logic [CTR_W-1:0] bit_period_i,
  output logic [CTR_W-1:0] slot_cnt_d_o,
  output logic             slot_last_o,
  output logic             byte_last_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [CTR_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;

  always_comb begin
    slot_last_o = run_i && (slot_cnt_q == (bit_period_i - CTR_W'(1)));
    byte_last_o = slot_last_o && (bit_idx_q == IDX_W'(DATA_W - 1));
    slot_cnt_d  = slot_cnt_q;
    bit_idx_d   = bit_idx_q;
    // A new acceptance restarts the byte even on the last cycle of the previous one
    if (start_i) begin
      slot_cnt_d = '0;
      bit_idx_d  = '0;
    end else if (slot_last_o) begin
      slot_cnt_d = '0;
      bit_idx_d  = byte_last_o ? '0 : bit_idx_q + IDX_W'(1);
    end else if (run_i) begin
      slot_cnt_d = slot_cnt_q + CTR_W'(1);
    end
  end

  assign slot_cnt_d_o = slot_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q <= '0;
      bit_idx_q  <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

endmodule

// File: rtl/modulator.sv
// On-off-keyed pulse modulator: serialises accepted bytes LSB-first, one
// bit_period slot per bit, with a pulse_width pulse at the start of each '1' slot.
module modulator
  import modulator_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CTR_W  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [MOD_NUM_FIELDS*CTR_W-1:0] mod_params,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            busy,
  output logic                            out
);

  state_e           state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CTR_W-1:0] pw_q, pw_d;
  logic [CTR_W-1:0] bp_q, bp_d;
  logic             out_q, out_d;

  logic [CTR_W-1:0] raw_pw, raw_bp, san_pw, san_bp;
  logic [CTR_W-1:0] slot_cnt_d;
  logic             slot_last, byte_last, accept;

  assign raw_pw = mod_params[MOD_PW_FIELD*CTR_W +: CTR_W];
  assign raw_bp = mod_params[MOD_BP_FIELD*CTR_W +: CTR_W];
  assign san_bp = (raw_bp == '0) ? CTR_W'(1) : raw_bp;
  assign san_pw = (raw_pw > san_bp) ? san_bp : raw_pw;

  assign in_ready = !reset && ((state_q == ST_IDLE) || byte_last);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == ST_SEND);
  assign out      = out_q;

  modulator_slot_timer #(
    .DATA_W(DATA_W),
    .CTR_W (CTR_W)
  ) u_slot_timer (
    .clk         (clk),
    .rst         (reset),
    .start_i     (accept),
    .run_i       (state_q == ST_SEND),
    .bit_period_i(bp_q),
    .slot_cnt_d_o(slot_cnt_d),
    .slot_last_o (slot_last),
    .byte_last_o (byte_last)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pw_d    = pw_q;
    bp_d    = bp_q;
    if (accept) begin
      state_d = ST_SEND;
      shift_d = in_data;
      pw_d    = san_pw;
      bp_d    = san_bp;
    end else if (byte_last) begin
      state_d = ST_IDLE;
    end else if (slot_last) begin
      shift_d = shift_q >> 1;
    end
    // Output is computed from next-cycle state so the pin itself is a flop
    out_d = (state_d == ST_SEND) && shift_d[0] && (slot_cnt_d < pw_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      pw_q    <= '0;
      bp_q    <= CTR_W'(1);
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pw_q    <= pw_d;
      bp_q    <= bp_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_modulator.sv
// Directed bench for the pulse modulator: expected waveforms come from a
// per-cycle model of the slot/pulse rules.
module tb_modulator;

  logic        clk;
  logic        reset;
  logic [31:0] mod_params;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic        out;

  int n_tests = 0;
  int n_fail  = 0;

  modulator #(.DATA_W(8), .CTR_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mod_params(mod_params),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected out in cycle T+i (i >= 1) for a byte accepted at edge T
  function automatic logic exp_out(input logic [7:0] d, input int pw, input int bp, input int i);
    int bpe;
    int pwe;
    int s;
    int c;
    bpe = (bp == 0) ? 1 : bp;
    pwe = (pw > bpe) ? bpe : pw;
    s   = (i - 1) / bpe;
    c   = (i - 1) % bpe;
    if (s >= 8) return 1'b0;
    return d[s] && (c < pwe);
  endfunction

  // Call at a negedge; returns after the acceptance edge (+1 time unit)
  task automatic accept(input logic [7:0] d, input int pw, input int bp, output int waited);
    in_data    = d;
    mod_params = {bp[15:0], pw[15:0]};
    in_valid   = 1'b1;
    waited     = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("[TB] accepted byte %02h pw=%0d bp=%0d after %0d wait cycles", d, pw, bp, waited);
  endtask

  task automatic trace(input string tag, input logic [7:0] d, input int pw, input int bp,
                       input int first, input int last);
    int bpe;
    bpe = (bp == 0) ? 1 : bp;
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      chk($sformatf("%s_out_T+%0d", tag, i), {31'd0, out}, {31'd0, exp_out(d, pw, bp, i)});
      chk($sformatf("%s_busy_T+%0d", tag, i), {31'd0, busy}, {31'd0, (i <= 8 * bpe)});
    end
  endtask

  int w;

  initial begin
    reset      = 1'b1;
    mod_params = '0;
    in_data    = '0;
    in_valid   = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out", {31'd0, out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Basic byte 0xA5, pw 3, bp 10
    accept(8'hA5, 3, 10, w);
    chk("a5_wait", w, 32'd0);
    for (int i = 1; i <= 82; i++) begin
      @(negedge clk);
      chk($sformatf("a5_out_T+%0d", i), {31'd0, out}, {31'd0, exp_out(8'hA5, 3, 10, i)});
      chk($sformatf("a5_busy_T+%0d", i), {31'd0, busy}, {31'd0, (i <= 80)});
      if (i == 79 || i == 80)
        chk($sformatf("a5_ready_T+%0d", i), {31'd0, in_ready}, {31'd0, (i == 80)});
    end

    // Back-to-back 0xFF then 0x01, pw 2, bp 4
    accept(8'hFF, 2, 4, w);
    in_data  = 8'h01;
    in_valid = 1'b1;
    trace("b2b0", 8'hFF, 2, 4, 1, 32);
    chk("b2b_ready_T+32", {31'd0, in_ready}, 32'd1);
    accept(8'h01, 2, 4, w);
    chk("b2b_wait", w, 32'd0);
    trace("b2b1", 8'h01, 2, 4, 1, 34);

    // Clamp: pw 9 > bp 5 on 0x03
    accept(8'h03, 9, 5, w);
    trace("clamp", 8'h03, 9, 5, 1, 42);

    // Zero pulse width on 0x03
    accept(8'h03, 0, 5, w);
    trace("pw0", 8'h03, 0, 5, 1, 42);

    // Mid-byte parameter change on 0x81
    accept(8'h81, 2, 8, w);
    trace("mid_a", 8'h81, 2, 8, 1, 10);
    mod_params = {16'd8, 16'd6};
    trace("mid_b", 8'h81, 2, 8, 11, 66);
    accept(8'h81, 6, 8, w);
    trace("mid_next", 8'h81, 6, 8, 1, 66);

    // bit_period 0 treated as 1
    accept(8'hAA, 1, 0, w);
    trace("bp0", 8'hAA, 1, 0, 1, 10);

    // Async reset during slot 2 of a '1' bit
    accept(8'h04, 6, 8, w);
    trace("ar", 8'h04, 6, 8, 1, 18);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_out_async", {31'd0, out}, 32'd0);
    chk("ar_busy_async", {31'd0, busy}, 32'd0);
    chk("ar_ready_in_rst", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ar_ready_after", {31'd0, in_ready}, 32'd1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk($sformatf("ar_idle_out_%0d", i), {31'd0, out}, 32'd0);
      chk($sformatf("ar_idle_busy_%0d", i), {31'd0, busy}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
